idli_fetch_m: RTL and testbench



---
 rtl/idli_fetch_m.sv | 146 ++++++++++++++
 tb/tb_idli_fetch_m.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/idli_fetch_m.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | idli_fetch_m : slice-serial instruction fetch with a DEPTH-entry queue.  |
// | Optional macro IDLI_FETCH_PERF_EN adds a saturating decode-stall count.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module idli_fetch_m #(
  parameter int DEPTH = 2
) (
  input  logic        i_fetch_gck,
  input  logic        i_fetch_rst_n,
  input  logic [1:0]  i_fetch_ctr,
  input  logic [3:0]  i_fetch_pc,
  input  logic        i_fetch_redirect,
  output logic        o_fetch_pc_inc,
  output logic        o_fetch_mem_req,
  output logic [3:0]  o_fetch_mem_addr,
  input  logic        i_fetch_mem_rvalid,
  input  logic [3:0]  i_fetch_mem_rdata,
  output logic        o_fetch_instr_vld,
  output logic [15:0] o_fetch_instr,
  input  logic        i_fetch_instr_rdy
`ifdef IDLI_FETCH_PERF_EN
  ,
  output logic [15:0] o_fetch_stall_cnt
`endif
);

  localparam int c_pw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cw = $clog2(DEPTH) + 1;
  localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2,
    ST_DATA = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_kill;
  logic [1:0]       r_slc;
  logic [15:0]      r_asm;
  logic [15:0]      r_mem [DEPTH];
  logic [c_pw-1:0]  r_rd;
  logic [c_pw-1:0]  r_wr;
  logic [c_cw-1:0]  r_count;

  logic             w_pop;
  logic             w_room;
  logic             w_start;
  logic             w_addr_ph;
  logic             w_last;
  logic             w_push;
  logic [15:0]      w_word;

  function automatic logic [c_pw-1:0] f_inc(input logic [c_pw-1:0] p);
    return (p == c_pw'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_fetch_instr_vld = (r_count != '0);
  assign o_fetch_instr     = o_fetch_instr_vld ? r_mem[r_rd] : 16'd0;

  // The fetch is launched in the ctr==0 cycle itself so the four address
  // slices line up with ctr 0..3; the reset term keeps outputs low in reset.
  assign w_pop     = o_fetch_instr_vld && i_fetch_instr_rdy;
  assign w_room    = (r_count < c_depth) || w_pop;
  assign w_start   = i_fetch_rst_n && (r_state == ST_IDLE) && (i_fetch_ctr == 2'd0)
                     && !i_fetch_redirect && w_room;
  assign w_addr_ph = w_start || (r_state == ST_ADDR);

  assign o_fetch_mem_req  = w_addr_ph;
  assign o_fetch_mem_addr = w_addr_ph ? i_fetch_pc : 4'd0;
  assign o_fetch_pc_inc   = w_addr_ph && !r_kill && !i_fetch_redirect;

  assign w_word = {i_fetch_mem_rdata, r_asm[15:4]};
  assign w_last = (r_state == ST_DATA) && i_fetch_mem_rvalid && (r_slc == 2'd3);
  assign w_push = w_last && !r_kill && !i_fetch_redirect;

  always_ff @(posedge i_fetch_gck or negedge i_fetch_rst_n) begin
    if (!i_fetch_rst_n) begin
      r_state <= ST_IDLE;
      r_kill  <= 1'b0;
      r_slc   <= 2'd0;
      r_asm   <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_start) r_state <= ST_ADDR;
        ST_ADDR: if (i_fetch_ctr == 2'd3) r_state <= ST_WAIT;
        ST_WAIT: if (i_fetch_mem_rvalid) r_state <= ST_DATA;
        ST_DATA: if (w_last) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
      if (i_fetch_mem_rvalid && ((r_state == ST_WAIT) || (r_state == ST_DATA))) begin
        r_asm <= w_word;
        r_slc <= r_slc + 2'd1;
      end
      // A redirect on the final slice already drops that word, so no kill lingers.
      if (w_last) begin
        r_kill <= 1'b0;
      end else if (i_fetch_redirect && (r_state != ST_IDLE)) begin
        r_kill <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_fetch_gck or negedge i_fetch_rst_n) begin
    if (!i_fetch_rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (i_fetch_redirect) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= f_inc(r_wr);
      if (w_pop)  r_rd <= f_inc(r_rd);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_fetch_gck) begin
    if (w_push) r_mem[r_wr] <= w_word;
  end

`ifdef IDLI_FETCH_PERF_EN
  logic [15:0] r_stall;

  always_ff @(posedge i_fetch_gck or negedge i_fetch_rst_n) begin
    if (!i_fetch_rst_n) begin
      r_stall <= 16'd0;
    end else if (i_fetch_instr_rdy && !o_fetch_instr_vld && (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign o_fetch_stall_cnt = r_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_idli_fetch_m.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_idli_fetch_m : randomized bench for idli_fetch_m against a            |
// | transaction-level queue model (honours IDLI_FETCH_PERF_EN).              |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_idli_fetch_m;

  localparam int DEPTH  = 2;
  localparam int CYCLES = 1600;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  ctr;
  logic [3:0]  pc;
  logic        redir;
  logic        pc_inc;
  logic        mem_req;
  logic [3:0]  mem_addr;
  logic        rvalid;
  logic [3:0]  rdata;
  logic        vld;
  logic [15:0] instr;
  logic        rdy;
`ifdef IDLI_FETCH_PERF_EN
  logic [15:0] stall_cnt;
  logic [15:0] e_stall;
`endif

  always #5 clk = ~clk;

  idli_fetch_m #(.DEPTH(DEPTH)) u_dut (
    .i_fetch_gck        (clk),
    .i_fetch_rst_n      (rst_n),
    .i_fetch_ctr        (ctr),
    .i_fetch_pc         (pc),
    .i_fetch_redirect   (redir),
    .o_fetch_pc_inc     (pc_inc),
    .o_fetch_mem_req    (mem_req),
    .o_fetch_mem_addr   (mem_addr),
    .i_fetch_mem_rvalid (rvalid),
    .i_fetch_mem_rdata  (rdata),
    .o_fetch_instr_vld  (vld),
    .o_fetch_instr      (instr),
    .i_fetch_instr_rdy  (rdy)
`ifdef IDLI_FETCH_PERF_EN
    ,
    .o_fetch_stall_cnt  (stall_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: expected queue contents plus one outstanding fetch record.
  logic [15:0] q[$];
  bit          busy;
  bit          kill;
  int          addr_n;
  int          data_n;
  logic [15:0] asm_w;

  // Bench-side memory: answers each 4-slice address with 4 data slices.
  int m_seen;
  int m_left;
  int m_lat;
  int m_idx;
  int rst_hold;

  bit          e_vld, e_req, e_inc, pop, start, done, push;
  logic [15:0] e_instr;
  logic [3:0]  e_addr;

  initial begin
    rst_n = 1'b0; ctr = 2'd0; pc = 4'd0; redir = 1'b0;
    rvalid = 1'b0; rdata = 4'd0; rdy = 1'b0;
    busy = 0; kill = 0; addr_n = 0; data_n = 0; asm_w = 16'd0;
    m_seen = 0; m_left = 0; m_lat = 0; m_idx = 0; rst_hold = 0;
`ifdef IDLI_FETCH_PERF_EN
    e_stall = 16'd0;
`endif
    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      @(posedge clk); #1;
      if (cyc >= 100 && rst_hold == 0 && $urandom_range(0, 199) == 0) rst_hold = 2;
      rst_n = (cyc >= 3) && (rst_hold == 0);
      if (rst_hold > 0) rst_hold--;
      ctr = 2'(cyc % 4);
      if (cyc < 40) begin
        rdy   = 1'b1;
        redir = 1'b0;
        pc    = 4'(16'h0010 >> (4 * (cyc % 4)));
      end else if (cyc < 100) begin
        rdy   = (cyc == 80);
        redir = 1'b0;
        pc    = 4'($urandom_range(0, 15));
      end else begin
        rdy   = 1'($urandom_range(0, 1));
        redir = ($urandom_range(0, 24) == 0);
        pc    = 4'($urandom_range(0, 15));
      end

      if (!rst_n) begin
        m_seen = 0; m_left = 0; m_lat = 0; m_idx = 0;
      end
      rvalid = 1'b0;
      rdata  = 4'd0;
      if (m_left > 0) begin
        if (m_lat > 0) begin
          m_lat--;
        end else if (cyc < 100 || $urandom_range(0, 3) != 0) begin
          rvalid = 1'b1;
          rdata  = (cyc < 40) ? 4'(4 - m_idx) : 4'($urandom_range(0, 15));
          m_idx++;
          m_left--;
        end
      end

      #3;
      if (!rst_n) begin
        e_vld = 0; e_instr = 16'd0; e_req = 0; e_addr = 4'd0; e_inc = 0; pop = 0; start = 0;
      end else begin
        e_vld   = (q.size() > 0);
        e_instr = e_vld ? q[0] : 16'd0;
        pop     = e_vld && rdy;
        start   = !busy && (ctr == 2'd0) && !redir && ((q.size() < DEPTH) || pop);
        e_req   = start || (busy && addr_n < 4);
        e_addr  = e_req ? pc : 4'd0;
        e_inc   = e_req && !kill && !redir;
      end
      check_eq("mem_req",  16'(mem_req),  16'(e_req));
      check_eq("mem_addr", 16'(mem_addr), 16'(e_addr));
      check_eq("pc_inc",   16'(pc_inc),   16'(e_inc));
      check_eq("vld",      16'(vld),      16'(e_vld));
      check_eq("instr",    instr,         e_instr);
`ifdef IDLI_FETCH_PERF_EN
      check_eq("stall_cnt", stall_cnt, e_stall);
`endif
      // Directed single fetch from PC 0x0010: slices 4,3,2,1 arrive two cycles late.
      if (cyc == 13) begin
        check_eq("single_vld",   16'(vld), 16'd1);
        check_eq("single_instr", instr,    16'h1234);
      end
      if (cyc == 14) check_eq("single_vld_drop", 16'(vld), 16'd0);

      if (!rst_n) begin
        q.delete();
        busy = 0; kill = 0; addr_n = 0; data_n = 0;
`ifdef IDLI_FETCH_PERF_EN
        e_stall = 16'd0;
`endif
      end else begin
`ifdef IDLI_FETCH_PERF_EN
        if (rdy && !e_vld && e_stall != 16'hFFFF) e_stall = e_stall + 16'd1;
`endif
        done = 0;
        push = 0;
        if (busy) begin
          if (addr_n < 4) begin
            addr_n++;
          end else if (rvalid) begin
            asm_w[4*data_n +: 4] = rdata;
            data_n++;
            if (data_n == 4) done = 1;
          end
        end
        if (done) begin
          push = !kill && !redir;
          busy = 0;
          kill = 0;
        end else if (busy && redir) begin
          kill = 1;
        end
        if (start) begin
          busy = 1; addr_n = 1; data_n = 0; asm_w = 16'd0;
        end
        if (redir) begin
          q.delete();
        end else begin
          if (pop)  void'(q.pop_front());
          if (push) q.push_back(asm_w);
        end
        if (mem_req) begin
          m_seen++;
          if (m_seen == 4) begin
            m_seen = 0;
            m_left = 4;
            m_idx  = 0;
            m_lat  = (cyc < 40) ? 1 : (cyc < 100) ? 0 : int'($urandom_range(0, 3));
          end
        end
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
